inst_cache: RTL

- Direct-mapped, one-word-per-line instruction cache between the CPU fetch port (pc / rom_ce / rom_data) and the instruction memory.
- Hits return the instruction in the same cycle, combinationally from registered arrays, so the pipeline sees a zero-wait ROM.
- A miss raises a stall request to ctrl and runs a req/ack refill on the memory side.

---
 rtl/inst_cache.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache with req/ack refill.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module inst_cache #(
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [ADDR_W-1:0] rom_addr_i,
  output logic [DATA_W-1:0] rom_data_o,
  output logic              stallreq_o,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int unsigned LINES = 1 << INDEX_W;
  localparam int unsigned TAG_W = ADDR_W - INDEX_W - 2;

  typedef enum logic {IDLE, REFILL} state_e;

  state_e              state_q, state_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_req_q, mem_req_d;
  logic [TAG_W-1:0]    tag_arr  [LINES];
  logic [DATA_W-1:0]   data_arr [LINES];

  logic [INDEX_W-1:0]  idx, fill_idx;
  logic [TAG_W-1:0]    tag, fill_tag;
  logic                hit;
  logic                refill_we;
  logic                unused_bits;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
`endif

  assign idx         = rom_addr_i[INDEX_W+1:2];
  assign tag         = rom_addr_i[ADDR_W-1:INDEX_W+2];
  assign fill_idx    = mem_addr_q[INDEX_W+1:2];
  assign fill_tag    = mem_addr_q[ADDR_W-1:INDEX_W+2];
  assign unused_bits = ^{rom_addr_i[1:0], mem_addr_q[1:0]};

  assign hit        = rom_ce_i & valid_q[idx] & (tag_arr[idx] == tag);
  assign rom_data_o = (hit && !rst) ? data_arr[idx] : '0;
  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;

  // Lookup / refill control; a refill write overrides a same-cycle flush.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;
    refill_we  = 1'b0;
    stallreq_o = 1'b0;
`ifdef ICACHE_STATS_EN
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
`endif
    if (flush_i) valid_d = '0;
    case (state_q)
      IDLE: begin
        if (rom_ce_i && !hit) begin
          stallreq_o = 1'b1;
          mem_addr_d = {tag, idx, 2'b00};
          mem_req_d  = 1'b1;
          state_d    = REFILL;
`ifdef ICACHE_STATS_EN
          if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
`endif
        end
`ifdef ICACHE_STATS_EN
        else if (hit && hit_cnt_q != 32'hFFFF_FFFF) begin
          hit_cnt_d = hit_cnt_q + 32'd1;
        end
`endif
      end
      REFILL: begin
        stallreq_o = 1'b1;
        if (mem_ack_i) begin
          refill_we         = 1'b1;
          valid_d[fill_idx] = 1'b1;
          mem_req_d         = 1'b0;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      stallreq_o = 1'b0;
      refill_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
`ifdef ICACHE_STATS_EN
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
`ifdef ICACHE_STATS_EN
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
`endif
    end
  end

  // Tag/data arrays carry no reset; valid_q qualifies them.
  always_ff @(posedge clk) begin
    if (refill_we) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= mem_data_i;
    end
  end

`ifdef ICACHE_STATS_EN
  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
